// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default timing and counter sizing for btn_cond
// Contents:
//   btn_st_t        2-bit per-channel debounce state
//   ST_*            state encodings IDLE / CHK_ON / HELD / CHK_OFF
//   *_DEF           default debounce and auto-repeat timing, in ce1ms ticks
//   btn_cnt_bits()  minimum tick counter width able to hold a given tick count
package btn_pkg;

   typedef logic [1:0] btn_st_t;

   localparam btn_st_t ST_IDLE    = 2'd0;
   localparam btn_st_t ST_CHK_ON  = 2'd1;
   localparam btn_st_t ST_HELD    = 2'd2;
   localparam btn_st_t ST_CHK_OFF = 2'd3;

   localparam int DB_MS_DEF      = 20;
   localparam int REP_DLY_MS_DEF = 500;
   localparam int REP_PER_MS_DEF = 100;
   localparam int CNT_W_DEF      = 10;

   function automatic int btn_cnt_bits(input int max_ticks);
      return (max_ticks < 2) ? 1 : $clog2(max_ticks + 1);
   endfunction

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button channel: synchroniser, debounce FSM, registered level/press/release
// Optional feature: define AUTOREPEAT_EN to add press auto-repeat while the button is held.
// Ports:
//   clk        in   system clock
//   R_n        in   asynchronous active-low reset
//   ce1ms      in   1-clk tick every millisecond, paces all counting
//   btn        in   raw asynchronous button pin, 1 = pressed
//   level      out  debounced state, 1 = held
//   press      out  1-clk pulse on debounced 0->1 (and repeats with AUTOREPEAT_EN)
//   release_p  out  1-clk pulse on debounced 1->0
module btn_chan
   import btn_pkg::*;
#(
   parameter int DB_MS      = DB_MS_DEF,
   parameter int REP_DLY_MS = REP_DLY_MS_DEF,
   parameter int REP_PER_MS = REP_PER_MS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic clk,
   input  logic R_n,
   input  logic ce1ms,
   input  logic btn,
   output logic level,
   output logic press,
   output logic release_p
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_MS - 1);

   logic             btn_meta_q, btn_meta_d;
   logic             s_q, s_d;
   btn_st_t          st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;

`ifdef AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REP_DLY_MS - 1);
   localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REP_PER_MS - 1);

   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   // 0: waiting out the initial hold delay, 1: in the periodic repeat phase
   logic             rep_per_q, rep_per_d;
`else
   logic unused_rep_cfg;
   assign unused_rep_cfg = (REP_DLY_MS > 0) ^ (REP_PER_MS > 0);
`endif

   always_comb begin
      btn_meta_d = btn;
      s_d        = btn_meta_q;
      st_d       = st_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
`ifdef AUTOREPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      rep_per_d  = rep_per_q;
      // Any time outside HELD wipes the repeat timer, so each entry into
      // HELD (fresh press or recovered glitch) starts the delay from zero.
      if (st_q != ST_HELD) begin
         rep_cnt_d = '0;
         rep_per_d = 1'b0;
      end
`endif

      case (st_q)
         ST_IDLE: begin
            if (s_q) begin
               st_d  = ST_CHK_ON;
               cnt_d = '0;
            end
         end

         // A revert is tested before the tick so a drop coinciding with the
         // qualifying tick still aborts the press.
         ST_CHK_ON: begin
            if (!s_q) begin
               st_d = ST_IDLE;
            end else if (ce1ms) begin
               if (cnt_q == DB_LAST) begin
                  st_d    = ST_HELD;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_HELD: begin
            if (!s_q) begin
               st_d  = ST_CHK_OFF;
               cnt_d = '0;
            end
`ifdef AUTOREPEAT_EN
            else if (ce1ms) begin
               if (!rep_per_q) begin
                  if (rep_cnt_q == REP_DLY_LAST) begin
                     press_d   = 1'b1;
                     rep_cnt_d = '0;
                     rep_per_d = 1'b1;
                  end else begin
                     rep_cnt_d = rep_cnt_q + CNT_W'(1);
                  end
               end else begin
                  if (rep_cnt_q == REP_PER_LAST) begin
                     press_d   = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + CNT_W'(1);
                  end
               end
            end
`endif
         end

         ST_CHK_OFF: begin
            if (s_q) begin
               st_d = ST_HELD;
            end else if (ce1ms) begin
               if (cnt_q == DB_LAST) begin
                  st_d    = ST_IDLE;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         btn_meta_q <= 1'b0;
         s_q        <= 1'b0;
         st_q       <= ST_IDLE;
         cnt_q      <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         rel_q      <= 1'b0;
      end else begin
         btn_meta_q <= btn_meta_d;
         s_q        <= s_d;
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
      end
   end

`ifdef AUTOREPEAT_EN
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         rep_cnt_q <= '0;
         rep_per_q <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_per_q <= rep_per_d;
      end
   end
`endif

   assign level     = level_q;
   assign press     = press_q;
   assign release_p = rel_q;

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - push-button conditioner: NCH independent debounced channels
// Optional feature: define AUTOREPEAT_EN to add press auto-repeat while a button is held.
// Ports:
//   clk        in   system clock
//   R_n        in   asynchronous active-low reset
//   ce1ms      in   1-clk tick every millisecond
//   BTN        in   [NCH] raw asynchronous button pins, 1 = pressed
//   level      out  [NCH] debounced state, 1 = held
//   press      out  [NCH] 1-clk pulse on debounced press (plus repeats when enabled)
//   release_p  out  [NCH] 1-clk pulse on debounced release
module btn_cond
   import btn_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int DB_MS      = DB_MS_DEF,
   parameter int REP_DLY_MS = REP_DLY_MS_DEF,
   parameter int REP_PER_MS = REP_PER_MS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           R_n,
   input  logic           ce1ms,
   input  logic [NCH-1:0] BTN,
   output logic [NCH-1:0] level,
   output logic [NCH-1:0] press,
   output logic [NCH-1:0] release_p
);

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      btn_chan #(
         .DB_MS      (DB_MS),
         .REP_DLY_MS (REP_DLY_MS),
         .REP_PER_MS (REP_PER_MS),
         .CNT_W      (CNT_W)
      ) u_chan (
         .clk       (clk),
         .R_n       (R_n),
         .ce1ms     (ce1ms),
         .btn       (BTN[g]),
         .level     (level[g]),
         .press     (press[g]),
         .release_p (release_p[g])
      );
   end

endmodule

// File: tb/tb_btn_cond.sv
// tb/tb_btn_cond.sv - scoreboard bench for btn_cond (DB_MS=3, REP 5/2, ce1ms every 10 clk)
module tb_btn_cond;

   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           R_n;
   logic           ce1ms;
   logic [NCH-1:0] BTN;
   logic [NCH-1:0] level;
   logic [NCH-1:0] press;
   logic [NCH-1:0] release_p;

   typedef struct {
      int ch;
      bit is_press;
      int tick;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   tick_n = 0;

   always #5 clk = ~clk;

   btn_cond #(
      .NCH        (NCH),
      .DB_MS      (3),
      .REP_DLY_MS (5),
      .REP_PER_MS (2),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .R_n       (R_n),
      .ce1ms     (ce1ms),
      .BTN       (BTN),
      .level     (level),
      .press     (press),
      .release_p (release_p)
   );

   // ce1ms: one-clk pulse every 10 clk, spanning exactly one rising edge
   initial begin
      ce1ms = 1'b0;
      forever begin
         repeat (9) @(negedge clk);
         ce1ms = 1'b1;
         @(negedge clk);
         ce1ms = 1'b0;
      end
   end

   always @(posedge clk) if (ce1ms) tick_n <= tick_n + 1;

   task automatic expect_pulse(input int ch, input bit is_press, input int ticks_ahead);
      exp_t e;
      e.ch       = ch;
      e.is_press = is_press;
      e.tick     = tick_n + ticks_ahead;
      exp_q.push_back(e);
   endtask

   task automatic check_pulse(input int ch, input bit is_press);
      int idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].ch == ch && exp_q[i].is_press == is_press) idx = i;
      total++;
      if (idx < 0) begin
         bad++;
         $display("FAIL unexpected_pulse ch=%0d press=%0d at tick %0d, required none", ch, is_press, tick_n);
         return;
      end
      if (exp_q[idx].tick != tick_n) begin
         bad++;
         $display("FAIL pulse_tick ch=%0d press=%0d got tick %0d required tick %0d",
                  ch, is_press, tick_n, exp_q[idx].tick);
      end
      total++;
      if (level[ch] != is_press) begin
         bad++;
         $display("FAIL level_at_pulse ch=%0d got %0b required %0b", ch, level[ch], is_press);
      end
      exp_q.delete(idx);
   endtask

   // Monitor: sample 1 time unit after each rising edge
   always @(posedge clk) begin
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         if (press[ch])     check_pulse(ch, 1'b1);
         if (release_p[ch]) check_pulse(ch, 1'b0);
      end
   end

   task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got %h required %h", name, got, want);
      end
   endtask

   task automatic wait_tick();
      int t0 = tick_n;
      int n  = 0;
      while (tick_n == t0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (tick_n == t0) begin
         total++;
         bad++;
         $display("FAIL tick_timeout got no tick in %0d clk, required one", n);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      R_n = 1'b0;
      BTN = 4'hF;
      repeat (5) @(negedge clk);
      chk("rst_level",   level,     4'h0);
      chk("rst_press",   press,     4'h0);
      chk("rst_release", release_p, 4'h0);

      // 1: release reset with BTN[0] held -> press after 3 ticks
      BTN = 4'h1;
      wait_tick();
      R_n = 1'b1;
      expect_pulse(0, 1'b1, 3);
      drain();
      wait_tick();
      BTN[0] = 1'b0;
      expect_pulse(0, 1'b0, 3);
      drain();

      // 2: bounce BTN[1] every 4 clk for 60 clk, last segment stays high
      wait_tick();
      for (int i = 0; i < 15; i++) begin
         BTN[1] = (i % 2 == 0);
         if (i == 14) expect_pulse(1, 1'b1, 3);
         repeat (4) @(negedge clk);
      end
      drain();
      chk("bounce_level", level, 4'h2);

      // 3: clean release, then re-press and a one-tick low glitch
      wait_tick();
      BTN[1] = 1'b0;
      expect_pulse(1, 1'b0, 3);
      drain();
      chk("release_level", level, 4'h0);
      wait_tick();
      BTN[1] = 1'b1;
      expect_pulse(1, 1'b1, 3);
      drain();
      BTN[1] = 1'b0;
      wait_tick();
      BTN[1] = 1'b1;
      wait_tick();
      chk("glitch_level", level, 4'h2);
      BTN[1] = 1'b0;
      expect_pulse(1, 1'b0, 3);
      drain();

      // 4: BTN[2] drops so that s falls on the edge carrying the 3rd tick
      wait_tick();
      BTN[2] = 1'b1;
      wait_tick();
      wait_tick();
      repeat (7) @(negedge clk);
      BTN[2] = 1'b0;
      repeat (4) wait_tick();
      chk("boundary_level", level, 4'h0);
      wait_tick();
      BTN[2] = 1'b1;
      expect_pulse(2, 1'b1, 3);
      drain();
      wait_tick();
      BTN[2] = 1'b0;
      expect_pulse(2, 1'b0, 3);
      drain();

      // 5: reset while BTN[3] is in CHK_ON with cnt=2
      wait_tick();
      BTN[3] = 1'b1;
      wait_tick();
      wait_tick();
      R_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_level", level, 4'h0);
      R_n = 1'b1;
      expect_pulse(3, 1'b1, 3);
      drain();
      wait_tick();
      BTN[3] = 1'b0;
      expect_pulse(3, 1'b0, 3);
      drain();

      // 6: hold BTN[0] for 20 ticks
      wait_tick();
      BTN[0] = 1'b1;
      expect_pulse(0, 1'b1, 3);
`ifdef AUTOREPEAT_EN
      for (int k = 0; k < 7; k++) expect_pulse(0, 1'b1, 8 + 2 * k);
`endif
      repeat (20) wait_tick();
      BTN[0] = 1'b0;
      expect_pulse(0, 1'b0, 3);
      drain();

      repeat (3) wait_tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_pulses got %0d outstanding required 0", exp_q.size());
         foreach (exp_q[i])
            $display("FAIL missing ch=%0d press=%0d tick=%0d", exp_q[i].ch, exp_q[i].is_press, exp_q[i].tick);
      end
      chk("final_level", level, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
